// File: rtl/spm_pkg.sv
// Shared types and constants for the RISC_SPM memory arbiter.
package spm_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  typedef enum logic {
    IDLE      = 1'b0,
    LDR_BURST = 1'b1
  } arb_state_t;

  // Round-robin choice: the side that was not served last wins a tie.
  function automatic owner_t rr_winner(input owner_t last_served);
    return (last_served == OWN_LDR) ? OWN_CPU : OWN_LDR;
  endfunction

endpackage

// File: rtl/spm_arb_pick.sv
// Combinational tie-break between CPU and loader for an unlocked cycle.
module spm_arb_pick
  import spm_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  input  owner_t last_served_i,
  input  logic   fair_i,
  output logic   valid_o,
  output owner_t owner_o
);

  always_comb begin
    valid_o = cpu_req_i | ldr_req_i;
    owner_o = OWN_LDR;
    if (cpu_req_i && !ldr_req_i) begin
      owner_o = OWN_CPU;
    end else if (cpu_req_i && ldr_req_i && fair_i) begin
      owner_o = rr_winner(last_served_i);
    end
  end

endmodule

// File: rtl/spm_mem_arbiter.sv
// Single-port RAM arbiter for RISC_SPM: CPU vs program loader with locked loader bursts.
// Define SPM_ARB_FAIR_EN for round-robin tie-break; otherwise the loader wins every tie.
module spm_mem_arbiter
  import spm_pkg::*;
#(
  parameter int ADDR_W    = spm_pkg::ADDR_W,
  parameter int DATA_W    = spm_pkg::DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_last,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic arb_fair;
`ifdef SPM_ARB_FAIR_EN
  assign arb_fair = 1'b1;
`else
  assign arb_fair = 1'b0;
`endif

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d, beat_cnt_inc;
  owner_t            last_served_q, last_served_d;
  logic              force_cpu_q, force_cpu_d;
  logic              rtag_valid_q, rtag_valid_d;
  owner_t            rtag_owner_q, rtag_owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic   gnt_cpu, gnt_ldr;
  logic   pick_valid;
  owner_t pick_owner;

  spm_arb_pick u_pick (
    .cpu_req_i     (cpu_req),
    .ldr_req_i     (ldr_req),
    .last_served_i (last_served_q),
    .fair_i        (arb_fair),
    .valid_o       (pick_valid),
    .owner_o       (pick_owner)
  );

  assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    last_served_d = last_served_q;
    force_cpu_d   = 1'b0;
    gnt_cpu       = 1'b0;
    gnt_ldr       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A forced burst release owes the waiting CPU the very next slot.
        if (force_cpu_q && cpu_req) begin
          gnt_cpu = 1'b1;
        end else if (pick_valid) begin
          gnt_cpu = (pick_owner == OWN_CPU);
          gnt_ldr = (pick_owner == OWN_LDR);
        end
      end
      LDR_BURST: begin
        gnt_ldr = ldr_req;
        if (!ldr_req) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase

    // beat_cnt_q is zero in IDLE, so one rule covers burst entry and continuation.
    if (gnt_ldr) begin
      last_served_d = OWN_LDR;
      if (ldr_last || (beat_cnt_inc >= MAX_CNT)) begin
        state_d     = IDLE;
        beat_cnt_d  = '0;
        force_cpu_d = !ldr_last && cpu_req;
      end else begin
        state_d    = LDR_BURST;
        beat_cnt_d = beat_cnt_inc;
      end
    end
    if (gnt_cpu) begin
      last_served_d = OWN_CPU;
    end
  end

  // Grants are gated by reset so nothing reaches the RAM while rst is high.
  assign cpu_gnt = gnt_cpu & ~rst;
  assign ldr_gnt = gnt_ldr & ~rst;

  always_comb begin
    mem_we       = 1'b0;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    rtag_valid_d = 1'b0;
    rtag_owner_d = rtag_owner_q;
    if (cpu_gnt) begin
      mem_we       = cpu_we;
      mem_addr     = cpu_addr;
      mem_wdata    = cpu_wdata;
      rtag_valid_d = ~cpu_we;
      rtag_owner_d = OWN_CPU;
    end else if (ldr_gnt) begin
      mem_we       = ldr_we;
      mem_addr     = ldr_addr;
      mem_wdata    = ldr_wdata;
      rtag_valid_d = ~ldr_we;
      rtag_owner_d = OWN_LDR;
    end
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      last_served_q <= OWN_LDR;
      force_cpu_q   <= 1'b0;
      rtag_valid_q  <= 1'b0;
      rtag_owner_q  <= OWN_CPU;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      last_served_q <= last_served_d;
      force_cpu_q   <= force_cpu_d;
      rtag_valid_q  <= rtag_valid_d;
      rtag_owner_q  <= rtag_owner_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign cpu_rvalid = rtag_valid_q && (rtag_owner_q == OWN_CPU);
  assign ldr_rvalid = rtag_valid_q && (rtag_owner_q == OWN_LDR);
  assign cpu_rdata  = mem_rdata;
  assign ldr_rdata  = mem_rdata;

endmodule
